// File: rtl/mpt_tlb.sv
// Fully-associative permission cache in front of the MPT table walker.
// Optional hit/miss counters are compiled in with `define MPT_TLB_STATS_EN.
module mpt_tlb #(
   parameter int PLEN        = 56,
   parameter int ENTRIES     = 8,
   parameter int PAGE_OFFSET = 12
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [PLEN-1:0] req_paddr_i,
   input  logic [1:0]      req_access_i,
   output logic            rsp_valid_o,
   output logic            rsp_allow_o,
   output logic            rsp_fault_o,
   output logic            ptw_enable_o,
   output logic            ptw_addr_valid_o,
   output logic [PLEN-1:0] ptw_paddr_o,
   output logic [1:0]      ptw_access_o,
   input  logic            ptw_busy_i,
   input  logic            ptw_valid_i,
   input  logic [2:0]      ptw_perm_i,
   input  logic            ptw_fault_i
`ifdef MPT_TLB_STATS_EN
   ,
   output logic [31:0]     hit_cnt_o,
   output logic [31:0]     miss_cnt_o
`endif
);

   localparam int TAG_W = PLEN - PAGE_OFFSET;
   localparam int IDX_W = $clog2(ENTRIES);

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WALK, S_WAIT, S_RESP} state_e;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [2:0]       perm;
   } entry_t;

   state_e            state_q, state_d;
   entry_t            ent_q [ENTRIES];
   logic [IDX_W-1:0]  rr_q;
   logic [PLEN-1:0]   paddr_q;
   logic [1:0]        access_q;
   logic              allow_q, allow_d, fault_q, fault_d;
   logic              nofill_q;
   logic              fill, lookup_hit, lookup_miss;
   logic [TAG_W-1:0]  req_tag;
   logic [ENTRIES-1:0] hit_vec;
   logic [2:0]        hit_perm;
   logic              hit, has_free;
   logic [IDX_W-1:0]  free_idx, fill_idx;

   assign req_tag = paddr_q[PLEN-1:PAGE_OFFSET];

   for (genvar g = 0; g < ENTRIES; g++) begin : g_cmp
      assign hit_vec[g] = ent_q[g].valid && (ent_q[g].tag == req_tag);
   end

   // A flush in the lookup cycle must not let a soon-to-be-dead entry answer.
   assign hit = (|hit_vec) && !flush_i;

   always_comb begin
      hit_perm = '0;
      has_free = 1'b0;
      free_idx = '0;
      for (int i = 0; i < ENTRIES; i++)
         if (hit_vec[i]) hit_perm = hit_perm | ent_q[i].perm;
      for (int i = ENTRIES-1; i >= 0; i--)
         if (!ent_q[i].valid) begin
            has_free = 1'b1;
            free_idx = IDX_W'(i);
         end
   end

   assign fill_idx = has_free ? free_idx : rr_q;

   always_comb begin
      state_d     = state_q;
      allow_d     = allow_q;
      fault_d     = fault_q;
      fill        = 1'b0;
      lookup_hit  = 1'b0;
      lookup_miss = 1'b0;
      unique case (state_q)
         S_IDLE:   if (req_valid_i) state_d = S_LOOKUP;
         S_LOOKUP: begin
            if (access_q == 2'd3) begin
               allow_d = 1'b0;
               fault_d = 1'b1;
               state_d = S_RESP;
            end else if (hit) begin
               allow_d    = hit_perm[access_q];
               fault_d    = 1'b0;
               lookup_hit = 1'b1;
               state_d    = S_RESP;
            end else begin
               lookup_miss = 1'b1;
               state_d     = S_WALK;
            end
         end
         S_WALK:   if (!ptw_busy_i) state_d = S_WAIT;
         S_WAIT: begin
            if (ptw_fault_i) begin
               allow_d = 1'b0;
               fault_d = 1'b1;
               state_d = S_RESP;
            end else if (ptw_valid_i) begin
               allow_d = ptw_perm_i[access_q];
               fault_d = 1'b0;
               fill    = !nofill_q && !flush_i;
               state_d = S_RESP;
            end
         end
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         rr_q     <= '0;
         paddr_q  <= '0;
         access_q <= '0;
         allow_q  <= 1'b0;
         fault_q  <= 1'b0;
         nofill_q <= 1'b0;
         for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
      end else begin
         state_q <= state_d;
         allow_q <= allow_d;
         fault_q <= fault_d;
         if (state_q == S_IDLE && req_valid_i) begin
            paddr_q  <= req_paddr_i;
            access_q <= req_access_i;
         end
         // A flush seen while the walk is outstanding suppresses its fill.
         if (state_q == S_LOOKUP)                nofill_q <= 1'b0;
         else if (state_q == S_WAIT && flush_i)  nofill_q <= 1'b1;
         if (flush_i) begin
            rr_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ent_q[i].valid <= 1'b0;
         end else if (fill) begin
            ent_q[fill_idx] <= '{valid: 1'b1, tag: req_tag, perm: ptw_perm_i};
            if (!has_free) rr_q <= rr_q + 1'b1;
         end
      end
   end

   assign req_ready_o      = (state_q == S_IDLE) && !rst_i;
   assign rsp_valid_o      = (state_q == S_RESP);
   assign rsp_allow_o      = rsp_valid_o && allow_q;
   assign rsp_fault_o      = rsp_valid_o && fault_q;
   assign ptw_enable_o     = (state_q == S_WALK) && !ptw_busy_i;
   assign ptw_addr_valid_o = ptw_enable_o;
   assign ptw_paddr_o      = paddr_q;
   assign ptw_access_o     = access_q;

`ifdef MPT_TLB_STATS_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
      end else begin
         if (lookup_hit && hit_cnt_o != 32'hFFFF_FFFF)   hit_cnt_o  <= hit_cnt_o + 32'd1;
         if (lookup_miss && miss_cnt_o != 32'hFFFF_FFFF) miss_cnt_o <= miss_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mpt_tlb.sv
// Bench for mpt_tlb: directed vector table, multi-cycle corner sequences,
// then randomized traffic against a reference permission-cache model.
module tb_mpt_tlb;
   localparam int PLEN = 56;
   localparam int ENTRIES = 8;

   logic            clk = 1'b0, rst = 1'b1, flush = 1'b0, req_valid = 1'b0;
   logic [PLEN-1:0] req_paddr = '0;
   logic [1:0]      req_access = '0;
   logic            ptw_busy = 1'b0, ptw_valid = 1'b0, ptw_fault = 1'b0;
   logic [2:0]      ptw_perm = '0;
   logic            req_ready, rsp_valid, rsp_allow, rsp_fault, ptw_enable, ptw_addr_valid;
   logic [PLEN-1:0] ptw_paddr;
   logic [1:0]      ptw_access;
`ifdef MPT_TLB_STATS_EN
   logic [31:0]     hit_cnt, miss_cnt;
`endif

   mpt_tlb #(.PLEN(PLEN), .ENTRIES(ENTRIES), .PAGE_OFFSET(12)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_paddr_i(req_paddr), .req_access_i(req_access),
      .rsp_valid_o(rsp_valid), .rsp_allow_o(rsp_allow), .rsp_fault_o(rsp_fault),
      .ptw_enable_o(ptw_enable), .ptw_addr_valid_o(ptw_addr_valid),
      .ptw_paddr_o(ptw_paddr), .ptw_access_o(ptw_access),
      .ptw_busy_i(ptw_busy), .ptw_valid_i(ptw_valid), .ptw_perm_i(ptw_perm),
      .ptw_fault_i(ptw_fault)
`ifdef MPT_TLB_STATS_EN
      , .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;

   function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endfunction

   // Reference model: a set of cached pages with first-free / round-robin placement.
   bit         m_v    [ENTRIES];
   logic [43:0] m_tag [ENTRIES];
   logic [2:0] m_perm [ENTRIES];
   int         m_ptr;

   function automatic void m_clear();
      for (int i = 0; i < ENTRIES; i++) m_v[i] = 0;
      m_ptr = 0;
   endfunction

   function automatic int m_find(logic [43:0] t);
      for (int i = 0; i < ENTRIES; i++) if (m_v[i] && m_tag[i] == t) return i;
      return -1;
   endfunction

   function automatic void m_fill(logic [43:0] t, logic [2:0] p);
      int slot = -1;
      for (int i = ENTRIES-1; i >= 0; i--) if (!m_v[i]) slot = i;
      if (slot < 0) begin
         slot  = m_ptr;
         m_ptr = (m_ptr + 1) % ENTRIES;
      end
      m_v[slot] = 1; m_tag[slot] = t; m_perm[slot] = p;
   endfunction

   // Issue one request and play the walker; cycles counted in negedges after accept.
   task automatic run_req(input logic [PLEN-1:0] a, input logic [1:0] acc, input logic [2:0] perm,
                          input bit flt, input bit both, input int lat, input int busy,
                          input int flush_at, output bit walked, output bit allow,
                          output bit fault, output int rlat);
      bit got = 0;
      int cyc = 0, resp_at = -1, pulses = 0;
      walked = 0; allow = 0; fault = 0; rlat = -1;
      @(negedge clk);
      chk("req_ready_idle", req_ready, 1);
      req_valid = 1; req_paddr = a; req_access = acc;
      @(posedge clk); #1;
      req_valid = 0;
      while (!got && cyc < 100) begin
         @(negedge clk);
         cyc++;
         ptw_busy  = (cyc <= busy);
         flush     = (cyc == flush_at);
         ptw_valid = (cyc == resp_at) && (!flt || both);
         ptw_fault = (cyc == resp_at) && flt;
         ptw_perm  = perm;
         #1;
         if (ptw_enable) begin
            pulses++; walked = 1; resp_at = cyc + lat;
            chk("walk_paddr", ptw_paddr, a);
            chk("walk_access", ptw_access, acc);
            chk("walk_addr_valid", ptw_addr_valid, 1);
            chk("enable_while_busy", ptw_busy, 0);
         end
         if (rsp_valid) begin
            got = 1; allow = rsp_allow; fault = rsp_fault; rlat = cyc;
         end else if (rsp_allow || rsp_fault)
            chk("rsp_gated", {rsp_allow, rsp_fault}, 0);
      end
      ptw_busy = 0; flush = 0; ptw_valid = 0; ptw_fault = 0;
      chk("rsp_seen", got, 1);
      chk("single_walk_pulse", pulses > 1, 0);
   endtask

   task automatic flush_idle();
      @(negedge clk); flush = 1;
      @(negedge clk); flush = 0;
   endtask

   typedef struct {
      logic [PLEN-1:0] a;
      logic [1:0]      acc;
      logic [2:0]      perm;
      bit              flt, both;
      int              lat;
      bit              e_walk, e_allow, e_fault;
      int              e_lat;
   } vec_t;

   vec_t tbl[$];

   task automatic apply(input string tag, input logic [PLEN-1:0] a, input logic [1:0] acc,
                        input logic [2:0] perm, input int lat, input int busy, input int flush_at,
                        input bit e_walk, input bit e_allow);
      bit w, al, fl;
      int rl;
      run_req(a, acc, perm, 1'b0, 1'b0, lat, busy, flush_at, w, al, fl, rl);
      chk({tag, "_walk"}, w, e_walk);
      chk({tag, "_allow"}, al, e_allow);
   endtask

   initial begin
      bit w, al, fl, seen;
      int rl;
      logic [PLEN-1:0] a;
      tbl.push_back(vec_t'{56'h8000_1234,        2'd0, 3'b001, 0, 0, 5, 1, 1, 0, 8});
      tbl.push_back(vec_t'{56'h8000_1FF0,        2'd1, 3'b111, 0, 0, 1, 0, 0, 0, 2});
      tbl.push_back(vec_t'{56'h8000_1000,        2'd2, 3'b111, 0, 0, 1, 0, 0, 0, 2});
      tbl.push_back(vec_t'{56'h8000_2000,        2'd0, 3'b111, 1, 1, 3, 1, 0, 1, 6});
      tbl.push_back(vec_t'{56'h8000_2000,        2'd0, 3'b011, 0, 0, 2, 1, 1, 0, 5});
      tbl.push_back(vec_t'{56'h8000_2ABC,        2'd1, 3'b000, 0, 0, 1, 0, 1, 0, 2});
      tbl.push_back(vec_t'{56'h8000_2ABC,        2'd3, 3'b111, 0, 0, 1, 0, 0, 1, 2});
      tbl.push_back(vec_t'{56'h9000_0000,        2'd3, 3'b111, 0, 0, 1, 0, 0, 1, 2});
      tbl.push_back(vec_t'{56'h8000_2000,        2'd2, 3'b111, 0, 0, 1, 0, 0, 0, 2});
      tbl.push_back(vec_t'{56'hFF_FFFF_FFFF_FFFF, 2'd2, 3'b100, 0, 0, 1, 1, 1, 0, 4});
      tbl.push_back(vec_t'{56'hFF_FFFF_FFFF_F000, 2'd2, 3'b000, 0, 0, 1, 0, 1, 0, 2});

      // Reset state, held for a few cycles.
      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_ptw_enable", ptw_enable, 0);
      chk("rst_ptw_paddr", ptw_paddr, 0);
      rst = 0;
      #1 chk("post_rst_ready", req_ready, 1);

      foreach (tbl[i]) begin
         run_req(tbl[i].a, tbl[i].acc, tbl[i].perm, tbl[i].flt, tbl[i].both, tbl[i].lat, 0, -1,
                 w, al, fl, rl);
         chk($sformatf("tbl%0d_walk", i), w, tbl[i].e_walk);
         chk($sformatf("tbl%0d_allow", i), al, tbl[i].e_allow);
         chk($sformatf("tbl%0d_fault", i), fl, tbl[i].e_fault);
         chk($sformatf("tbl%0d_lat", i), rl, tbl[i].e_lat);
      end

      // Reset while a walk is outstanding, then a late walker result.
      @(negedge clk);
      req_valid = 1; req_paddr = 56'h5555_5000; req_access = 2'd1;
      @(posedge clk); #1 req_valid = 0;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk); #1;
         if (ptw_enable) seen = 1;
      end
      chk("rstwalk_walk_seen", seen, 1);
      @(negedge clk);
      rst = 1;
      #1;
      chk("rstwalk_ready", req_ready, 0);
      chk("rstwalk_rsp_valid", rsp_valid, 0);
      chk("rstwalk_rsp_allow", rsp_allow, 0);
      chk("rstwalk_rsp_fault", rsp_fault, 0);
      chk("rstwalk_enable", ptw_enable, 0);
      chk("rstwalk_addr_valid", ptw_addr_valid, 0);
      chk("rstwalk_paddr", ptw_paddr, 0);
      chk("rstwalk_access", ptw_access, 0);
      @(negedge clk);
      rst = 0;
      #1 chk("rstwalk_ready_after", req_ready, 1);
      ptw_valid = 1; ptw_perm = 3'b111;
      @(negedge clk);
      ptw_valid = 0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("late_valid_no_rsp", rsp_valid, 0);
         @(negedge clk);
      end
      apply("post_rst_cache_empty", 56'h8000_1234, 2'd0, 3'b001, 1, 0, -1, 1, 1);

      // Capacity and round-robin eviction.
      flush_idle();
      for (int i = 0; i < 9; i++)
         apply($sformatf("fill_p%0d", i), (56'h100 + 56'(i)) << 12, 2'd0, 3'b111, 1, 0, -1, 1, 1);
      apply("evict_p1_hit", 56'h101 << 12, 2'd0, 3'b111, 1, 0, -1, 0, 1);
      apply("evict_p0_walk", 56'h100 << 12, 2'd0, 3'b111, 1, 0, -1, 1, 1);
      apply("evict_p1_walk", 56'h101 << 12, 2'd0, 3'b111, 1, 0, -1, 1, 1);
      apply("evict_p3_hit", 56'h103 << 12, 2'd0, 3'b111, 1, 0, -1, 0, 1);

      // Flush during WAIT, coincident with fill, and during LOOKUP.
      flush_idle();
      apply("flush_wait", 56'h6000_0000, 2'd0, 3'b111, 5, 0, 4, 1, 1);
      apply("flush_wait_again", 56'h6000_0000, 2'd0, 3'b111, 1, 0, -1, 1, 1);
      apply("flush_fill", 56'h6100_0000, 2'd1, 3'b111, 3, 0, 5, 1, 1);
      apply("flush_fill_again", 56'h6100_0000, 2'd1, 3'b111, 1, 0, -1, 1, 1);
      apply("flush_lookup", 56'h6100_0000, 2'd1, 3'b111, 1, 0, 1, 1, 1);
      apply("flush_lookup_refill", 56'h6100_0000, 2'd1, 3'b111, 1, 0, -1, 0, 1);

      // Walker busy stalls the issue.
      run_req(56'h6200_0000, 2'd2, 3'b100, 1'b0, 1'b0, 1, 3, -1, w, al, fl, rl);
      chk("busy_walk", w, 1);
      chk("busy_allow", al, 1);
      chk("busy_lat", rl, 6);

      // Randomized traffic against the model.
      flush_idle();
      m_clear();
      for (int n = 0; n < 300; n++) begin
         logic [1:0] acc;
         logic [2:0] perm;
         bit flt, both;
         int lat, busy, idx, elat;
         bit ew, ea, ef;
         if ($urandom_range(0, 19) == 0) begin
            flush_idle();
            m_clear();
         end
         a    = ((56'h700 + 56'($urandom_range(0, 11))) << 12) | 56'($urandom_range(0, 4095));
         acc  = 2'($urandom_range(0, 3));
         perm = 3'($urandom_range(0, 7));
         flt  = ($urandom_range(0, 5) == 0);
         both = 1'($urandom_range(0, 1));
         lat  = $urandom_range(1, 4);
         busy = $urandom_range(0, 2);
         idx  = m_find(a[55:12]);
         if (acc == 2'd3) begin
            ew = 0; ea = 0; ef = 1; elat = 2;
         end else if (idx >= 0) begin
            ew = 0; ea = m_perm[idx][acc]; ef = 0; elat = 2;
         end else begin
            ew = 1; ef = flt; ea = !flt && perm[acc];
            elat = ((busy + 1 > 2) ? busy + 1 : 2) + lat + 1;
            if (!flt) m_fill(a[55:12], perm);
         end
         run_req(a, acc, perm, flt, both, lat, busy, -1, w, al, fl, rl);
         chk($sformatf("rnd%0d_walk", n), w, ew);
         chk($sformatf("rnd%0d_allow", n), al, ea);
         chk($sformatf("rnd%0d_fault", n), fl, ef);
         chk($sformatf("rnd%0d_lat", n), rl, elat);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, vectors %0d", n_vec);
      $fatal(1);
   end
endmodule
